// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs MULT/MULTU/DIV/DIVU
// over a fixed number of busy cycles and applies MTHI/MTLO immediately.
module md_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        div_zero;

    // Datapath results, evaluated from the live operands and captured only on a start edge.
    logic        is_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        is_signed = ~md_op[0];

        // Sign- or zero-extending to 64 bits lets one unsigned multiply serve both forms.
        mul_a   = {{32{is_signed & src_a[31]}}, src_a};
        mul_b   = {{32{is_signed & src_b[31]}}, src_b};
        product = mul_a * mul_b;

        // Signed divide on magnitudes keeps 0x80000000 / -1 well defined (lo = 0x80000000).
        neg_a   = is_signed & src_a[31];
        neg_b   = is_signed & src_b[31];
        mag_a   = neg_a ? (~src_a + 32'd1) : src_a;
        mag_b   = neg_b ? (~src_b + 32'd1) : src_b;
        divisor = (src_b == 32'd0) ? 32'd1 : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;

        quotient  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
        remainder = neg_a ? (~r_mag + 32'd1) : r_mag;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            cnt      <= 4'd0;
            p_hi     <= 32'd0;
            p_lo     <= 32'd0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (md_valid) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                p_hi     <= product[63:32];
                                p_lo     <= product[31:0];
                                div_zero <= 1'b0;
                                cnt      <= MUL_LOAD;
                                state    <= S_MUL;
                                busy     <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                p_hi     <= remainder;
                                p_lo     <= quotient;
                                div_zero <= (src_b == 32'd0);
                                cnt      <= DIV_LOAD;
                                state    <= S_DIV;
                                busy     <= 1'b1;
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end

                S_MUL, S_DIV: begin
                    // Requests arriving while occupied are dropped; the hazard unit prevents them.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (!((state == S_DIV) && div_zero)) begin
                            hi <= p_hi;
                            lo <= p_lo;
                        end
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: multiply/divide results, busy length,
// divide-by-zero hold, ignored requests while busy, reset abort and back-to-back starts.
module tb_md_unit;

    logic        clk;
    logic        rst_n;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_valid (md_valid),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_valid = 1'b1;
        md_op    = op;
        src_a    = a;
        src_b    = b;
        step();
        md_valid = 1'b0;
    endtask

    // Expects busy high for n cycles (operands scrambled meanwhile), then low.
    task automatic expect_busy(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s busy[%0d]", tag, i), {31'd0, busy}, 32'd1);
            src_a = 32'hDEAD_BEEF ^ i;
            src_b = 32'h0BAD_F00D + i;
            step();
        end
        check($sformatf("%s busy_fall", tag), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        md_valid = 1'b0;
        md_op    = 3'd0;
        src_a    = 32'd0;
        src_b    = 32'd0;
        #2;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        #12 rst_n = 1'b1;
        step();

        // MULT -3 * 5
        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        expect_busy("mult", 5);
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFF1);

        // MULTU 0xFFFFFFFF * 2
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        expect_busy("multu", 5);
        check("multu hi", hi, 32'h0000_0001);
        check("multu lo", lo, 32'hFFFF_FFFE);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        expect_busy("div", 10);
        check("div lo", lo, 32'hFFFF_FFFD);
        check("div hi", hi, 32'hFFFF_FFFF);

        // MTHI / MTLO preload, then DIVU by zero leaves HI/LO alone
        issue(3'd4, 32'h0000_1234, 32'd0);
        check("mthi hi", hi, 32'h0000_1234);
        check("mthi busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h0000_5678, 32'd0);
        check("mtlo lo", lo, 32'h0000_5678);
        check("mtlo hi kept", hi, 32'h0000_1234);
        issue(3'd3, 32'd7, 32'd0);
        expect_busy("divu0", 10);
        check("divu0 hi", hi, 32'h0000_1234);
        check("divu0 lo", lo, 32'h0000_5678);

        // Signed overflow case
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_busy("divovf", 10);
        check("divovf lo", lo, 32'h8000_0000);
        check("divovf hi", hi, 32'h0000_0000);

        // MULT with MTLO in busy cycle 2 and reset in busy cycle 4
        issue(3'd0, 32'd6, 32'd7);
        step();
        md_valid = 1'b1;
        md_op    = 3'd5;
        src_a    = 32'h0000_AAAA;
        step();
        md_valid = 1'b0;
        check("abort mtlo ignored", lo, 32'h8000_0000);
        check("abort busy3", {31'd0, busy}, 32'd1);
        step();
        #1 rst_n = 1'b0;
        #1;
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("abort no commit hi", hi, 32'd0);
        check("abort no commit lo", lo, 32'd0);
        check("abort idle", {31'd0, busy}, 32'd0);

        // MULTU 3*4 then DIVU 100/7 back to back
        issue(3'd1, 32'd3, 32'd4);
        expect_busy("b2b mul", 5);
        check("b2b mul lo", lo, 32'd12);
        check("b2b mul hi", hi, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        expect_busy("b2b div", 10);
        check("b2b div lo", lo, 32'd14);
        check("b2b div hi", hi, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the EX stage of the five-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID/EX register and holds the architectural HI/LO registers. A multiply occupies the unit for a fixed 5 cycles and a divide for 10 cycles. Its `busy` output feeds the hazard unit, which stalls F/D and flushes E when a HI/LO-using instruction in D meets a busy or starting unit.

## Interface
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU (legal range 1..15).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (legal range 1..15).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `md_valid`  in  1  E-stage instruction is an MD operation this cycle.
- `md_op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored.
- `src_a`  in  32  rs value after forwarding.
- `src_b`  in  32  rt value after forwarding.
- `busy`  out  1  unit is occupied by a multiply or divide; registered.
- `hi`  out  32  HI register; registered.
- `lo`  out  32  LO register; registered.

## Operation
- States: IDLE, MUL, DIV. A 4-bit down-counter `cnt` is active in MUL and DIV.
- IDLE, `md_valid`, op 0/1:
  - compute the 64-bit product (signed for 0, unsigned for 1) into pending registers `p_hi` = [63:32], `p_lo` = [31:0];
  - load `cnt` = MUL_CYCLES; go to MUL.
- IDLE, `md_valid`, op 2/3:
  - compute quotient into `p_lo` and remainder into `p_hi` (signed for 2, unsigned for 3);
  - load `cnt` = DIV_CYCLES; go to DIV.
- Signed divide:
  - quotient truncates toward zero; remainder takes the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Divide by zero (`src_b` = 0): the unit goes busy for DIV_CYCLES as normal, but HI/LO are left unchanged at commit.
- IDLE, `md_valid`, op 4: `hi` <= `src_a` at the edge; busy stays 0.
- IDLE, `md_valid`, op 5: `lo` <= `src_a` at the edge; busy stays 0.
- MUL/DIV:
  - `cnt` decrements every cycle;
  - on the edge where `cnt` = 1: `hi` <= `p_hi`, `lo` <= `p_lo` (except divide by zero); state goes to IDLE.
- While in MUL/DIV, any `md_valid` is ignored: no restart, no MTHI/MTLO effect. The hazard unit guarantees this case does not occur; the block defines the behaviour anyway.
- `busy` = 1 exactly when state != IDLE.
- The unit performs no HI/LO forwarding. Reads of `hi`/`lo` (MFHI/MFLO in E) see the committed registers only; the hazard unit stalls them while `busy` is high or `md_valid` is high.

## Timing
- Reset (`rst_n` = 0, asynchronous): `hi` = 0, `lo` = 0, `busy` = 0, state IDLE, `cnt` = 0, pending registers 0.
- Reset mid-operation aborts the operation: no commit, and HI/LO read 0 after reset.
- Start sampled at edge t: `busy` is 1 during cycles t+1 .. t+N, where N = MUL_CYCLES or DIV_CYCLES.
  - New `hi`/`lo` become visible in cycle t+N+1, the same cycle `busy` falls.
- Back-to-back operation: a new start may be presented in the first cycle with `busy` = 0. It is accepted with no bubble.
- MTHI/MTLO: single-cycle latency; new value is visible the cycle after the edge.
- Operand values are captured only at the start edge. Changes on `src_a`/`src_b` while busy have no effect.

## Test plan
- MULT: `src_a` = 0xFFFFFFFD (-3), `src_b` = 5.
  - Required: `busy` high 5 cycles.
  - Then hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- MULTU: `src_a` = 0xFFFFFFFF, `src_b` = 2.
  - Required: hi = 0x00000001, lo = 0xFFFFFFFE after 5 busy cycles.
- DIV: `src_a` = 0xFFFFFFF9 (-7), `src_b` = 2.
  - Required: `busy` high 10 cycles.
  - Then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU: `src_a` = 7, `src_b` = 0, with HI/LO preloaded via MTHI 0x1234 and MTLO 0x5678.
  - Required: `busy` high 10 cycles.
  - hi = 0x1234 and lo = 0x5678 unchanged.
- MULT started, MTLO 0xAAAA presented in busy cycle 2, `rst_n` pulsed low in busy cycle 4.
  - Required: MTLO ignored.
  - Immediately on reset: hi = lo = 0, `busy` = 0; no commit afterwards.
- MULTU 3×4 followed by DIVU 100/7 presented in the first cycle `busy` is low.
  - Required: lo = 12 on that cycle.
  - DIVU accepted with no bubble.
  - 10 busy cycles later: lo = 14, hi = 2.
